// File: rtl/tdm_demux8.sv
// Eight-channel TDM receive demux: routes accepted serial bits to slots 0..7, emits each frame
// as a registered byte one edge after its slot-7 bit; no backpressure, din_valid gaps just stall.
module tdm_demux8 #(
  parameter bit CHECK_SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] asm_q, asm_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sync_err_q, sync_err_d;

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    slot_d       = slot_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;

    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          asm_d   = {7'b0, din};
          slot_d  = 3'd1;
          state_d = RUN;
        end
      end else if (frame_sync && (slot_q != 3'd0)) begin
        // Early marker: abandon the partial frame and realign on this bit.
        sync_err_d = 1'b1;
        asm_d      = {7'b0, din};
        slot_d     = 3'd1;
      end else if (CHECK_SYNC && !frame_sync && (slot_q == 3'd0)) begin
        sync_err_d = 1'b1;
        slot_d     = 3'd0;
        state_d    = HUNT;
      end else begin
        asm_d[slot_q] = din;
        slot_d        = slot_q + 3'd1;
        if (slot_q == 3'd7) begin
          dout_d       = {din, asm_q[6:0]};
          dout_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      asm_q        <= 8'h00;
      slot_q       <= 3'd0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == RUN);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized scoreboard bench for tdm_demux8 against a bit-list reference model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  localparam bit CS = 1'b1;

  tdm_demux8 #(.CHECK_SYNC(CS)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected pulses: bit 8 set = sync error, clear = frame with value in [7:0].
  logic [8:0] exp_q[$];
  logic [8:0] ev;
  bit         mon_en = 1'b0;

  // Reference model: alignment flag, bits collected so far, last delivered frame.
  bit         m_locked = 1'b0;
  bit         m_bits[$];
  logic [7:0] m_dout = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit r, bit v, bit d, bit fs);
    logic [7:0] w;
    if (r) begin
      m_locked = 1'b0;
      m_bits.delete();
      m_dout = 8'h00;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1;
          m_bits.delete();
          m_bits.push_back(d);
        end
      end else if (fs && m_bits.size() != 0) begin
        exp_q.push_back(9'h100);
        m_bits.delete();
        m_bits.push_back(d);
      end else if (CS && !fs && m_bits.size() == 0) begin
        exp_q.push_back(9'h100);
        m_locked = 1'b0;
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == 8) begin
          w = 8'h00;
          foreach (m_bits[i]) w[i] = m_bits[i];
          m_dout = w;
          exp_q.push_back({1'b0, w});
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic cycle(bit r, bit v, bit d, bit fs);
    @(negedge clk);
    #1;
    rst        = r;
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    model_step(r, v, d, fs);
    mon_en = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] v, int gap_pct);
    for (int i = 0; i < 8; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct)
        cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle(1'b0, 1'b1, v[i], i == 0);
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse, checks steady outputs each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid || sync_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: dout_valid=%b sync_err=%b, none expected at %0t",
                   dout_valid, sync_err, $time);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", {30'd0, dout_valid, sync_err}, ev[8] ? 32'd1 : 32'd2);
          if (!ev[8]) chk("frame_data", {24'd0, dout}, {24'd0, ev[7:0]});
        end
      end else if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: no pulse, expected %s (%0h) at %0t",
                 ev[8] ? "sync_err" : "dout_valid", ev[7:0], $time);
      end
      chk("slot", {29'd0, slot}, m_locked ? m_bits.size() : 0);
      chk("locked", {31'd0, locked}, {31'd0, m_locked});
      chk("dout_hold", {24'd0, dout}, {24'd0, m_dout});
    end
  end

  initial begin
    logic [7:0] v;
    int         k;

    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(8'hA5, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(8'h01, 0);
    send_frame(8'h80, 0);
    send_frame(8'hFF, 0);

    // Frame with five gap cycles, frame_sync toggling while din_valid is low.
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, v[i], i == 0);
      if (i == 3) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (i == 5) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Early marker on the 4th bit; that bit starts 0x5A.
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, 0);

    // Missing marker on slot 0 drops lock, then relock.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h96, 0);

    // Reset with slot=5.
    v = 8'h77;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, v[i], i == 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 0);

    for (int n = 0; n < 80; n++) begin
      v = 8'($urandom);
      case ($urandom_range(0, 6))
        0: begin
          k = $urandom_range(1, 7);
          cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
          for (int i = 1; i < k; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
          send_frame(v, 15);
        end
        1: begin
          k = $urandom_range(1, 10);
          for (int i = 0; i < k; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        2: begin
          k = $urandom_range(0, 7);
          for (int i = 0; i < k; i++) cycle(1'b0, 1'b1, v[i], i == 0);
          cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        default: send_frame(v, 20);
      endcase
    end

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Eight-channel time-division demultiplexer: the receive end of the serial link whose transmit side walks a 3-bit select across an 8:1 mux. It takes one bit per accepted slot plus a frame marker, routes each bit to the channel addressed by an internal slot counter, and presents the assembled 8-bit frame as a registered word with a one-cycle valid pulse. It sits between the serial link and the parallel consumers, and owns frame alignment and error reporting.

## Interface
- CHECK_SYNC, 1: 1 means frame_sync must accompany every slot-0 bit while locked, and a missing marker drops lock. 0 means only an early frame_sync is checked.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  din (and frame_sync) are sampled on this cycle.
- frame_sync  input  1  marks the bit on din as slot 0; meaningful only when din_valid=1.
- dout  output  8  last complete frame; dout[k] is the bit received in slot k.
- dout_valid  output  1  one-cycle pulse: dout was just updated.
- slot  output  3  slot index the next accepted bit will occupy.
- locked  output  1  1 while in RUN.
- sync_err  output  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT (not aligned) and RUN (aligned). Internal 8-bit assembly register asm, plus slot counter slot.
- Only cycles with din_valid=1 are "accepted"; all other cycles change nothing except clearing the pulses.
- HUNT:
  - Accepted bit with frame_sync=0: discarded.
  - Accepted bit with frame_sync=1: asm[0]←din, slot←1, go to RUN.
- RUN, accepted bit, slot=s:
  - s≠0 and frame_sync=1 (early marker): sync_err pulse; partial frame dropped; asm cleared; bit taken as new slot 0 (asm[0]←din, slot←1); stay RUN; no dout update.
  - s=0 and frame_sync=0 with CHECK_SYNC=1: sync_err pulse; bit discarded; slot←0; go to HUNT.
  - s=0 and frame_sync=0 with CHECK_SYNC=0: bit accepted as slot 0.
  - Otherwise: asm[s]←din; slot←s+1, wrapping 7→0.
  - s=7 accepted normally: dout←{din, asm[6:0]}, dout_valid pulse; slot wraps to 0.
- dout holds its value between frames and across error or HUNT periods; it changes only on a complete frame.
- Simultaneous cases:
  - Early marker at s=7: the error rule wins and dout is not updated.
  - frame_sync with din_valid=0 is ignored in every state.

## Timing
- All outputs are registered.
- Reset values: dout=8'h00, dout_valid=0, sync_err=0, locked=0, slot=0, state=HUNT, asm=0.
- rst has priority over all inputs on the same edge; reset mid-frame discards asm without a dout update.
- Latency: dout and dout_valid update on the clock edge that accepts the slot-7 bit. They are visible in the cycle after din_valid for slot 7 is presented.
- sync_err is a one-cycle pulse registered on the edge that accepts the offending bit.
- locked follows state and is registered on the same edge as the state change.
- Throughput: one bit per cycle with din_valid held high; 8 cycles per frame; back-to-back frames give one dout_valid every 8 cycles.
- Gaps (din_valid=0) of any length within a frame are tolerated; there is no timeout.

## Test plan
- Reset, then send frame 0xA5 LSB-first (slot 0 bit=1 with frame_sync), din_valid continuous → locked=1 after the first bit; dout=8'hA5 with a single dout_valid pulse the cycle after the 8th bit; slot returns to 0.
- Three back-to-back frames 0x01, 0x80, 0xFF, each with frame_sync on slot 0 → dout_valid every 8 cycles; dout values 01, 80, FF in order; sync_err never asserts.
- Frame 0x3C with din_valid deasserted for 5 random cycles mid-frame, and frame_sync pulsed during a din_valid=0 cycle → dout=8'h3C; no sync_err; slot frozen during the gaps.
- Early marker: frame_sync with the 4th bit of a frame, then 7 more bits forming 0x5A → sync_err pulse at the 4th bit with no dout update; next dout=8'h5A.
- CHECK_SYNC=1, slot-0 bit sent without frame_sync after a good frame → sync_err pulse; locked=0; dout keeps its prior value. Next frame_sync relocks and the following frame is delivered correctly.
- Assert rst when slot=5 mid-frame → next cycle all outputs are at reset values (dout=00, locked=0). A subsequent frame 0xC3 is delivered intact.
